// File: rtl/vec_split.sv
// vec_split: re-emits a packed LSB-first stream of W-bit vectors as BUS_WIDTH-bit
// sub-vectors. The final piece of each vector is zero-padded in its MSBs. W is
// latched from cfg_VecWidth on the first word of every batch.
// Optional feature macro: VEC_SPLIT_STATS_EN adds the stat_VecCnt / stat_StallCnt
// counters. With the macro undefined those ports and counters do not exist.
//
// state   | meaning
// IDLE    | waiting for the first word of a batch
// RUN     | batch open: accept words and emit sub-vectors
// DRAIN   | up_Last seen: emit complete vectors, discard or truncate the residue
// DISCARD | illegal width latched: swallow words until up_Last
module vec_split #(
  parameter int BUS_WIDTH        = 128,
  parameter int MAX_VECTOR_WIDTH = 1024,
  parameter int VEC_ID_WIDTH     = 8,
  parameter int LEN_WIDTH        = $clog2(MAX_VECTOR_WIDTH + 1)
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [LEN_WIDTH-1:0]    cfg_VecWidth,
  input  logic [BUS_WIDTH-1:0]    up_Vector,
  input  logic                    up_Valid,
  input  logic                    up_Last,
  output logic                    up_Ready,
  output logic [BUS_WIDTH-1:0]    dn_Vector,
  output logic [VEC_ID_WIDTH-1:0] dn_VecID,
  output logic                    dn_Valid,
  output logic                    dn_SubLast,
  output logic                    dn_Last,
  input  logic                    dn_Ready,
  output logic                    err_Cfg,
  output logic                    err_Trunc
`ifdef VEC_SPLIT_STATS_EN
  ,
  output logic [31:0]             stat_VecCnt,
  output logic [31:0]             stat_StallCnt
`endif
);

  localparam int BUF_W  = 2 * BUS_WIDTH;
  localparam int FILL_W = $clog2(BUF_W + 1);
  // Common width for all length arithmetic so no compare or sum can overflow.
  localparam int CW     = ((LEN_WIDTH > FILL_W) ? LEN_WIDTH : FILL_W) + 2;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DISCARD} state_t;

  state_t                  state_q, state_d;
  logic [BUF_W-1:0]        buf_q, buf_d;
  logic [FILL_W-1:0]       fill_q, fill_d;
  logic [LEN_WIDTH-1:0]    rem_q, rem_d;
  logic [LEN_WIDTH-1:0]    width_q, width_d;
  logic [VEC_ID_WIDTH-1:0] vec_id_q, vec_id_d;
  logic                    err_cfg_q, err_cfg_d;
  logic                    err_trunc_q, err_trunc_d;

  logic [CW-1:0]           fill_x, rem_x, width_x, take_x, bus_x, fill_sh;
  logic [BUF_W-1:0]        buf_sh, word_x;
  logic [BUS_WIDTH-1:0]    take_mask;
  logic                    cfg_bad;
  logic                    ready_int, valid_int, sublast_int, last_int;
  logic                    trunc, discard, emit, accept;

  assign fill_x  = CW'(fill_q);
  assign rem_x   = CW'(rem_q);
  assign width_x = CW'(width_q);
  assign bus_x   = CW'(BUS_WIDTH);
  assign take_x  = (rem_x > bus_x) ? bus_x : rem_x;
  assign word_x  = {{BUS_WIDTH{1'b0}}, up_Vector};
  assign cfg_bad = (cfg_VecWidth == '0) || (cfg_VecWidth > LEN_WIDTH'(MAX_VECTOR_WIDTH));
  // Only the low take bits of the buffer belong to the current vector.
  assign take_mask = (take_x >= bus_x) ? '1 : ~({BUS_WIDTH{1'b1}} << take_x);

  // Next-state, handshake and buffer bookkeeping.
  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    fill_d      = fill_q;
    rem_d       = rem_q;
    width_d     = width_q;
    vec_id_d    = vec_id_q;
    err_cfg_d   = err_cfg_q;
    err_trunc_d = err_trunc_q;
    ready_int   = 1'b0;
    valid_int   = 1'b0;
    trunc       = 1'b0;
    discard     = 1'b0;

    case (state_q)
      S_IDLE:    ready_int = 1'b1;
      S_RUN: begin
        ready_int = (fill_x <= bus_x);
        valid_int = (fill_x >= take_x);
      end
      S_DRAIN: begin
        // A vector that cannot be completed from the buffer is never started.
        if ((rem_q == width_q) && (fill_x < width_x)) begin
          discard = 1'b1;
        end else begin
          valid_int = 1'b1;
          trunc     = (fill_x < take_x);
        end
      end
      S_DISCARD: ready_int = 1'b1;
      default:   ready_int = 1'b0;
    endcase

    sublast_int = valid_int && (trunc || (rem_x <= bus_x));
    last_int    = valid_int && (state_q == S_DRAIN) &&
                  (trunc || (sublast_int && (fill_x < take_x + width_x)));

    emit    = valid_int && dn_Ready;
    accept  = up_Valid && ready_int && rstn;
    buf_sh  = emit ? (buf_q >> take_x) : buf_q;
    fill_sh = emit ? (fill_x - take_x) : fill_x;

    if (emit) begin
      if (rem_x <= bus_x) begin
        rem_d    = width_q;
        vec_id_d = (vec_id_q == '1) ? VEC_ID_WIDTH'(1) : vec_id_q + VEC_ID_WIDTH'(1);
      end else begin
        rem_d = rem_q - LEN_WIDTH'(take_x);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          width_d  = cfg_VecWidth;
          rem_d    = cfg_VecWidth;
          vec_id_d = VEC_ID_WIDTH'(1);
          if (cfg_bad) begin
            err_cfg_d = 1'b1;
            state_d   = up_Last ? S_IDLE : S_DISCARD;
          end else begin
            buf_d   = word_x;
            fill_d  = FILL_W'(BUS_WIDTH);
            state_d = up_Last ? S_DRAIN : S_RUN;
          end
        end
      end
      S_RUN: begin
        if (accept) begin
          buf_d  = buf_sh | (word_x << fill_sh);
          fill_d = FILL_W'(fill_sh + bus_x);
          if (up_Last) state_d = S_DRAIN;
        end else begin
          buf_d  = buf_sh;
          fill_d = FILL_W'(fill_sh);
        end
      end
      S_DRAIN: begin
        if (discard || (emit && last_int)) begin
          state_d = S_IDLE;
          buf_d   = '0;
          fill_d  = '0;
          if (emit && trunc) err_trunc_d = 1'b1;
        end else begin
          buf_d  = buf_sh;
          fill_d = FILL_W'(fill_sh);
        end
      end
      S_DISCARD: begin
        if (accept && up_Last) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      buf_q       <= '0;
      fill_q      <= '0;
      rem_q       <= '0;
      width_q     <= '0;
      vec_id_q    <= VEC_ID_WIDTH'(1);
      err_cfg_q   <= 1'b0;
      err_trunc_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      fill_q      <= fill_d;
      rem_q       <= rem_d;
      width_q     <= width_d;
      vec_id_q    <= vec_id_d;
      err_cfg_q   <= err_cfg_d;
      err_trunc_q <= err_trunc_d;
    end
  end

  assign up_Ready   = ready_int && rstn;
  assign dn_Valid   = valid_int;
  assign dn_SubLast = sublast_int;
  assign dn_Last    = last_int;
  assign dn_Vector  = valid_int ? (buf_q[BUS_WIDTH-1:0] & take_mask) : '0;
  assign dn_VecID   = vec_id_q;
  assign err_Cfg    = err_cfg_q;
  assign err_Trunc  = err_trunc_q;

`ifdef VEC_SPLIT_STATS_EN
  logic [31:0] vec_cnt_q, stall_cnt_q;

  // Saturating counters of completed vectors and downstream stall cycles.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      vec_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (emit && sublast_int && (vec_cnt_q != '1)) vec_cnt_q <= vec_cnt_q + 32'd1;
      if (valid_int && !dn_Ready && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stat_VecCnt   = vec_cnt_q;
  assign stat_StallCnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_vec_split.sv
// Scoreboard bench for vec_split: a reference model slices the word stream into
// W-bit vectors and queues the expected sub-vectors; a monitor pops on every
// downstream handshake.
module tb_vec_split;
  localparam int BW  = 128;
  localparam int IDW = 8;
  localparam int LW  = 11;

  logic           clk = 1'b0;
  logic           rstn;
  logic [LW-1:0]  cfg_VecWidth;
  logic [BW-1:0]  up_Vector;
  logic           up_Valid, up_Last, up_Ready;
  logic [BW-1:0]  dn_Vector;
  logic [IDW-1:0] dn_VecID;
  logic           dn_Valid, dn_SubLast, dn_Last, dn_Ready;
  logic           err_Cfg, err_Trunc;
`ifdef VEC_SPLIT_STATS_EN
  logic [31:0]    stat_VecCnt, stat_StallCnt;
`endif

  vec_split dut (
    .clk(clk), .rstn(rstn), .cfg_VecWidth(cfg_VecWidth),
    .up_Vector(up_Vector), .up_Valid(up_Valid), .up_Last(up_Last), .up_Ready(up_Ready),
    .dn_Vector(dn_Vector), .dn_VecID(dn_VecID), .dn_Valid(dn_Valid),
    .dn_SubLast(dn_SubLast), .dn_Last(dn_Last), .dn_Ready(dn_Ready),
    .err_Cfg(err_Cfg), .err_Trunc(err_Trunc)
`ifdef VEC_SPLIT_STATS_EN
    , .stat_VecCnt(stat_VecCnt), .stat_StallCnt(stat_StallCnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [BW-1:0]  data;
    logic [IDW-1:0] id;
    logic           sub;
    logic           last;
  } beat_t;

  beat_t         exp_q[$];
  beat_t         mon_e;
  int            checks = 0;
  int            failures = 0;
  int            beats_seen = 0;
  int            bubbles = 0;
  int            ready_mode = 0;
  logic [BW-1:0] held;
  logic          held_v = 1'b0;

  // Downstream ready pattern: 0 always, 1 alternate, 2 random, 3 never.
  initial begin
    dn_Ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       dn_Ready = 1'b1;
        1:       dn_Ready = ~dn_Ready;
        2:       dn_Ready = ($urandom_range(0, 2) != 0);
        default: dn_Ready = 1'b0;
      endcase
    end
  end

  // Monitor: stability under stall and scoreboard compare on each handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (!rstn) begin
        held_v = 1'b0;
      end else begin
        if (up_Valid && !up_Ready) bubbles++;
        if (held_v) begin
          checks++;
          if (!dn_Valid || dn_Vector !== held) begin
            failures++;
            $display("FAIL stall_hold valid=%0b vector=%h required=%h", dn_Valid, dn_Vector, held);
          end
        end
        held_v = 1'b0;
        if (dn_Valid && !dn_Ready) begin
          held   = dn_Vector;
          held_v = 1'b1;
        end
        if (dn_Valid && dn_Ready) begin
          beats_seen++;
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_beat id=%0d vector=%h required=none", dn_VecID, dn_Vector);
          end else begin
            mon_e = exp_q.pop_front();
            if (dn_Vector !== mon_e.data || dn_VecID !== mon_e.id ||
                dn_SubLast !== mon_e.sub || dn_Last !== mon_e.last) begin
              failures++;
              $display("FAIL beat actual id=%0d sub=%0b last=%0b data=%h required id=%0d sub=%0b last=%0b data=%h",
                       dn_VecID, dn_SubLast, dn_Last, dn_Vector, mon_e.id, mon_e.sub, mon_e.last, mon_e.data);
            end
          end
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [BW-1:0] rand_word();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Stream bit p lives in words[p/BW][p%BW]; vector v occupies bits [v*w +: w].
  task automatic build_expect(input int w, input logic [BW-1:0] words[$]);
    int    total, k, nb, p;
    beat_t b;
    total = words.size() * BW;
    k     = total / w;
    nb    = (w + BW - 1) / BW;
    for (int v = 0; v < k; v++) begin
      for (int j = 0; j < nb; j++) begin
        b.data = '0;
        for (int i = 0; i < BW; i++) begin
          if (j * BW + i < w) begin
            p = v * w + j * BW + i;
            b.data[i] = words[p / BW][p % BW];
          end
        end
        b.id   = IDW'((v % 255) + 1);
        b.sub  = (j == nb - 1);
        b.last = (j == nb - 1) && (v == k - 1);
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic send_word(input logic [BW-1:0] d, input logic l);
    int n;
    n = 0;
    up_Vector = d;
    up_Last   = l;
    up_Valid  = 1'b1;
    forever begin
      @(negedge clk);
      if (up_Ready) break;
      n++;
      if (n > 2000) begin
        checks++;
        failures++;
        $display("FAIL up_accept_timeout actual=stalled required=accepted");
        break;
      end
    end
    @(posedge clk);
    #1;
    up_Valid = 1'b0;
    up_Last  = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s drain_timeout pending=%0d required=0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  // cfg_VecWidth is scrambled after the first word to show it is ignored mid-batch.
  task automatic run_batch(input string name, input int w, input logic [BW-1:0] words[$],
                           input bit model);
    cfg_VecWidth = LW'(w);
    if (model) build_expect(w, words);
    for (int i = 0; i < words.size(); i++) begin
      send_word(words[i], i == words.size() - 1);
      if (i == 0) cfg_VecWidth = LW'($urandom_range(0, 2047));
    end
    wait_drain(name);
  endtask

  logic [BW-1:0] wq[$];
  logic [BW-1:0] w920[$];
  int            base;
  beat_t         tb;

  initial begin
    rstn = 1'b0; cfg_VecWidth = '0; up_Vector = '0; up_Valid = 1'b0; up_Last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_up_ready", up_Ready, 0);
    chk("rst_dn_valid", dn_Valid, 0);
    chk("rst_dn_vecid", dn_VecID, 1);
    rstn = 1'b1;
    @(negedge clk);
    chk("idle_up_ready", up_Ready, 1);
    chk("idle_dn_valid", dn_Valid, 0);
    chk("idle_err_cfg", err_Cfg, 0);
    chk("idle_err_trunc", err_Trunc, 0);
    @(posedge clk);
    #1;

    // W=920, 15 words: two vectors of 8 beats, 80 residue bits dropped.
    ready_mode = 0;
    for (int i = 0; i < 15; i++) w920.push_back(rand_word());
    base = beats_seen;
    run_batch("w920", 920, w920, 1'b1);
    chk("w920_beats", beats_seen - base, 16);

    // W=256, 4 words at full rate.
    wq.delete();
    for (int i = 0; i < 4; i++) wq.push_back(rand_word());
    base = beats_seen; bubbles = 0;
    run_batch("w256", 256, wq, 1'b1);
    chk("w256_beats", beats_seen - base, 4);
    chk("w256_bubbles", bubbles, 0);

    // Same W=920 stream under alternating backpressure.
    ready_mode = 1;
    base = beats_seen;
    run_batch("w920_bp", 920, w920, 1'b1);
    chk("w920_bp_beats", beats_seen - base, 16);

    // Small width: 288 vectors, IDs wrap past 255 back to 1.
    ready_mode = 0;
    wq.delete();
    for (int i = 0; i < 9; i++) wq.push_back(rand_word());
    run_batch("w4_wrap", 4, wq, 1'b1);

    // Random widths/lengths whose residue is shorter than one word.
    ready_mode = 2;
    for (int b = 0; b < 12; b++) begin
      int w, n, k, l, nb;
      w = 128; n = 2;
      for (int t = 0; t < 200; t++) begin
        w  = $urandom_range(1, 1024);
        n  = $urandom_range(1, 12);
        k  = n * BW / w;
        l  = n * BW - k * w;
        nb = (w + BW - 1) / BW;
        if (k >= 1 && l < BW && k * nb <= 600) break;
      end
      k  = n * BW / w;
      l  = n * BW - k * w;
      nb = (w + BW - 1) / BW;
      if (!(k >= 1 && l < BW && k * nb <= 600)) begin
        w = 128; n = 2;
      end
      wq.delete();
      for (int i = 0; i < n; i++) wq.push_back(rand_word());
      run_batch("random", w, wq, 1'b1);
    end
    chk("random_err_cfg", err_Cfg, 0);
    chk("random_err_trunc", err_Trunc, 0);

    // Illegal widths: W=0 on 3 words, W=1500 on a single last word.
    ready_mode = 0;
    wq.delete();
    for (int i = 0; i < 3; i++) wq.push_back(rand_word());
    base = beats_seen;
    run_batch("w0", 0, wq, 1'b0);
    chk("w0_err_cfg", err_Cfg, 1);
    wq.delete();
    wq.push_back(rand_word());
    run_batch("w1500", 1500, wq, 1'b0);
    chk("illegal_beats", beats_seen - base, 0);
    chk("illegal_up_ready", up_Ready, 1);

    // Normal batch after an illegal one; error stays sticky.
    wq.delete();
    for (int i = 0; i < 2; i++) wq.push_back(rand_word());
    base = beats_seen;
    run_batch("w128", 128, wq, 1'b1);
    chk("w128_beats", beats_seen - base, 2);
    chk("w128_err_cfg_sticky", err_Cfg, 1);

    // W=300 on 2 words: third beat is the zero-padded remainder of vector 1.
    chk("pre_trunc_err", err_Trunc, 0);
    wq.delete();
    for (int i = 0; i < 2; i++) wq.push_back(rand_word());
    tb.data = wq[0]; tb.id = 1; tb.sub = 0; tb.last = 0; exp_q.push_back(tb);
    tb.data = wq[1]; tb.id = 1; tb.sub = 0; tb.last = 0; exp_q.push_back(tb);
    tb.data = '0;    tb.id = 1; tb.sub = 1; tb.last = 1; exp_q.push_back(tb);
    run_batch("w300_trunc", 300, wq, 1'b0);
    chk("w300_err_trunc", err_Trunc, 1);

    // Reset in the middle of a vector, then a fresh batch.
    ready_mode = 3;
    cfg_VecWidth = LW'(920);
    send_word(rand_word(), 1'b0);
    send_word(rand_word(), 1'b0);
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete();
    rstn = 1'b1;
    ready_mode = 0;
    @(negedge clk);
    chk("post_rst_valid", dn_Valid, 0);
    chk("post_rst_vecid", dn_VecID, 1);
    chk("post_rst_err_cfg", err_Cfg, 0);
    chk("post_rst_err_trunc", err_Trunc, 0);
`ifdef VEC_SPLIT_STATS_EN
    chk("post_rst_stat_vec", stat_VecCnt, 0);
    chk("post_rst_stat_stall", stat_StallCnt, 0);
`endif
    @(posedge clk);
    #1;
    wq.delete();
    for (int i = 0; i < 2; i++) wq.push_back(rand_word());
    base = beats_seen;
    run_batch("after_rst", 256, wq, 1'b1);
    chk("after_rst_beats", beats_seen - base, 2);
`ifdef VEC_SPLIT_STATS_EN
    chk("after_rst_stat_vec", stat_VecCnt, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vec_split.md
Name: vec_split

Overview:
- Runtime-configurable successor to the input vector separator at the accelerator front end.
- Takes a continuous LSB-first packed stream of fixed-width binary fingerprint vectors on a BUS_WIDTH bus and re-emits each vector as ceil(W/BUS_WIDTH) sub-vectors, one vector per output word sequence, zero-padded in the MSBs of the final piece.
- Vector width W is a per-batch runtime setting rather than a compile-time constant.
- Adds a per-vector last flag, batch drain with residue discard, full AXI-style backpressure and error flags.
- Feeds the popcount/compare pipeline.

Parameters:
- BUS_WIDTH, 128, input/output word width in bits.
- MAX_VECTOR_WIDTH, 1024, largest legal runtime vector width.
- VEC_ID_WIDTH, 8, width of the vector ID output.
- LEN_WIDTH, $clog2(MAX_VECTOR_WIDTH+1), width of the cfg_VecWidth port.

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- cfg_VecWidth  in  LEN_WIDTH  vector width W; sampled at batch start only
- up_Vector  in  BUS_WIDTH  packed input stream; stream bit k*W+i is bit i of vector k
- up_Valid  in  1  input word valid
- up_Last  in  1  last word of batch
- up_Ready  out  1  input word accepted when up_Valid && up_Ready
- dn_Vector  out  BUS_WIDTH  sub-vector j holds vector bits [j*BUS_WIDTH +: BUS_WIDTH]; bits at or above W are zero
- dn_VecID  out  VEC_ID_WIDTH  ID of the vector being emitted
- dn_Valid  out  1  output valid
- dn_SubLast  out  1  final sub-vector of the current vector
- dn_Last  out  1  final sub-vector of the final complete vector of the batch
- dn_Ready  in  1  downstream accept
- err_Cfg  out  1  sticky: illegal width latched at batch start
- err_Trunc  out  1  sticky: batch ended mid-vector

Behaviour:
- Reset applies everywhere: rstn is synchronous and active-low, clock is clk. Reset values: state IDLE, r_Fill=0, all outputs 0, except dn_VecID=1. Reset mid-batch discards all buffered data, with no partial output afterwards.
- Storage:
  - 2*BUS_WIDTH residue buffer r_Buf with fill count r_Fill (0..2*BUS_WIDTH), consumed from the LSB side.
  - Accepted words are appended at bit position r_Fill.
- Per-emit counters: r_Rem = bits left in the current vector, reloaded to W at each vector start; take = min(BUS_WIDTH, r_Rem).
- States: IDLE, RUN, DRAIN, DISCARD.
- IDLE:
  - up_Ready=1.
  - On the first accepted word, latch W=cfg_VecWidth, r_Rem=W, dn_VecID=1.
  - If W==0 or W>MAX_VECTOR_WIDTH: set err_Cfg and go to DISCARD; if up_Last is also set on that word, return to IDLE instead.
  - Otherwise go to RUN, or to DRAIN if up_Last is set on that word.
- RUN:
  - up_Ready = (r_Fill <= BUS_WIDTH).
  - dn_Valid = (r_Fill >= take). dn_Valid depends on registers only, never on dn_Ready.
  - On dn handshake: r_Fill -= take, the buffer shifts right by take, and r_Rem -= take.
  - When r_Rem reaches 0: assert dn_SubLast on that beat, reload r_Rem=W, and increment dn_VecID. The ID wraps from 2^VEC_ID_WIDTH-1 to 1; ID 0 is reserved.
  - Accepting a word with up_Last moves to DRAIN.
- Simultaneous accept and emit in one cycle: r_Fill' = r_Fill + BUS_WIDTH - take.
- Throughput: 1 word/cycle sustained when W is a multiple of BUS_WIDTH. Otherwise one up_Ready bubble is allowed whenever r_Fill exceeds BUS_WIDTH.
- DRAIN:
  - up_Ready=0. Emit while r_Fill >= take.
  - dn_Last=1 on a dn_SubLast beat when the remaining fill after the beat is < W.
  - At a vector boundary with r_Fill < W: discard the residue, set r_Fill=0, go to IDLE.
  - Mid-vector with r_Fill < take: emit the remainder zero-padded with dn_SubLast=1 and dn_Last=1, set err_Trunc, then go to IDLE.
- DISCARD: up_Ready=1, dn_Valid=0; drop words until up_Last is accepted, then go to IDLE.
- Latency: first input accepted in cycle t gives dn_Valid at t+1 at the earliest. Outputs are driven from registered state and buffer.
- Error flags err_Cfg and err_Trunc clear only on reset.
- cfg_VecWidth changes outside IDLE are ignored.

Optional Feature:
- Macro: VEC_SPLIT_STATS_EN.
- Defined:
  - Adds output stat_VecCnt (32 bits), counting dn_SubLast handshakes.
  - Adds output stat_StallCnt (32 bits), counting cycles with dn_Valid && !dn_Ready.
  - Both are free-running, cleared only by reset, and saturate at 2^32-1.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Setup: BUS_WIDTH=128, W=920, 2 vectors in 15 words, the last with up_Last, dn_Ready=1.
  - Expect 16 beats: 8 per vector, dn_SubLast on beats 8 and 16, dn_Last on beat 16 only, IDs 1 then 2.
  - Beats 8 and 16 have dn_Vector[127:24]=0; the 80 pad bits are discarded; state returns to IDLE.
- W=256, 4 words -> 4 beats, no up_Ready bubble, dn_SubLast on beats 2 and 4.
- W=920 with dn_Ready toggling every other cycle -> same data and order as the first scenario; dn_Vector held stable while dn_Valid && !dn_Ready.
- W=0 on a 3-word batch -> err_Cfg=1, all 3 words accepted, no dn_Valid; the next batch with W=128 outputs normally.
- W=300, 2 words with up_Last -> 3 beats: beat 3 carries bits [299:256] in dn_Vector[43:0] with upper bits zero, dn_Last=1, err_Trunc=1.
- rstn=0 mid-vector, then a new batch -> no stale beats, first new beat has ID 1; with VEC_SPLIT_STATS_EN, counters read 0 after reset.
